// File: rtl/display_scan_if.sv
// Signal bundle between the display scan controller and the segment mux / display side.
interface display_scan_if;
   logic       EN;
   logic [3:0] MASK;
   logic [6:0] SEG_IN;
   logic [1:0] S;
   logic [6:0] SEG_OUT;
   logic [3:0] AN;
   logic       FRAME;

   modport master (output EN, output MASK, output SEG_IN,
                   input S, input SEG_OUT, input AN, input FRAME);
   modport slave  (input EN, input MASK, input SEG_IN,
                   output S, output SEG_OUT, output AN, output FRAME);
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit 7-segment scan controller: fixed-length slots, each opening with a blank
// interval, registered active-low segment/anode outputs and a per-frame pulse.
module display_scan_ctrl #(
   parameter int unsigned PRESCALE     = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input logic           clk,
   input logic           rst_n,
   display_scan_if.slave bus
);

   localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    s_q, s_d;
   logic          lit_q, lit_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          frame_q, frame_d;

   // Next-state and next-output computation for the scan sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      lit_d   = lit_q;
      an_d    = an_q;
      seg_d   = seg_q;
      frame_d = 1'b0;
      if (!bus.EN) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         s_d     = 2'd0;
         lit_d   = 1'b0;
         an_d    = 4'hF;
         seg_d   = 7'h7F;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               s_d     = 2'd0;
               lit_d   = 1'b0;
               an_d    = 4'hF;
               seg_d   = 7'h7F;
            end
            ST_BLANK: begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == BLANK_LAST) begin
                  // The digit mask is captured once here and held for the whole on-time.
                  state_d = ST_ON;
                  lit_d   = bus.MASK[s_q];
                  an_d    = bus.MASK[s_q] ? ~(4'b0001 << s_q) : 4'hF;
                  seg_d   = bus.MASK[s_q] ? bus.SEG_IN : 7'h7F;
               end else begin
                  state_d = ST_BLANK;
                  an_d    = 4'hF;
                  seg_d   = 7'h7F;
               end
            end
            ST_ON: begin
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_BLANK;
                  cnt_d   = '0;
                  s_d     = s_q + 2'd1;
                  lit_d   = 1'b0;
                  an_d    = 4'hF;
                  seg_d   = 7'h7F;
                  frame_d = (s_q == 2'd3);
               end else begin
                  state_d = ST_ON;
                  cnt_d   = cnt_q + CW'(1);
                  seg_d   = lit_q ? bus.SEG_IN : 7'h7F;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               s_d     = 2'd0;
               lit_d   = 1'b0;
               an_d    = 4'hF;
               seg_d   = 7'h7F;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         s_q     <= 2'd0;
         lit_q   <= 1'b0;
         an_q    <= 4'hF;
         seg_q   <= 7'h7F;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         lit_q   <= lit_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         frame_q <= frame_d;
      end
   end

   assign bus.S       = s_q;
   assign bus.AN      = an_q;
   assign bus.SEG_OUT = seg_q;
   assign bus.FRAME   = frame_q;

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scan controller for the four-digit 7-segment display path. It drives the 2-bit select of the 7-bit 4:1 segment mux, takes the selected pattern back, and produces the registered segment bus and active-low digit enables for the display. Each digit gets a fixed-length time slot, and every slot starts with an anti-ghosting blank interval. A frame pulse marks each completed 4-digit sweep so upstream logic can update digit data without tearing.

## Interface
- PRESCALE, 50000: clock cycles per digit slot; legal range PRESCALE ≥ 2.
- BLANK_CYCLES, 500: blank cycles at the start of each slot; legal range 1 ≤ BLANK_CYCLES < PRESCALE.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- EN  input  1  scan enable; low forces IDLE.
- MASK  input  4  per-digit enable; MASK[k] = 0 keeps digit k dark during its slot.
- SEG_IN  input  7  active-low segment pattern returned by the mux for the current S.
- S  output  2  select driven to the segment mux (digit index).
- SEG_OUT  output  7  registered active-low segments to the display.
- AN  output  4  registered active-low digit enables; at most one bit low.
- FRAME  output  1  one-cycle pulse at the start of each new frame.

## Operation
- States: IDLE, BLANK, ON.
- Registers:
  - Slot counter cnt, width clog2(PRESCALE).
  - Digit index S.
  - Registered outputs AN, SEG_OUT, FRAME.
- Reset values (rst_n low at an edge): state IDLE, cnt 0, S 0, AN 4'hF, SEG_OUT 7'h7F, FRAME 0.
- IDLE: outputs at reset values. If EN is high at an edge, go to BLANK with S = 0 and cnt = 0.
- BLANK: AN = 4'hF and SEG_OUT = 7'h7F; cnt increments each cycle. When cnt = BLANK_CYCLES−1, go to ON on the next edge.
- ON: cnt keeps incrementing.
  - AN = ~(4'b0001 << S) if MASK[S] = 1, else 4'hF.
  - SEG_OUT = SEG_IN registered every cycle; it is 7'h7F if MASK[S] = 0.
- Slot end: when cnt = PRESCALE−1 in ON, the next edge sets cnt = 0, S = S+1 (mod 4, so 3 wraps to 0), and state = BLANK.
- FRAME is high for exactly the one cycle after the edge where S wraps from 3 to 0. It is not asserted on the initial IDLE→BLANK entry.
- MASK is sampled at the BLANK→ON edge of each slot and held for the rest of that slot. A change during ON takes effect in the next slot.
- EN low at any edge, in any state: next state IDLE, all outputs and cnt/S at reset values. Re-asserting EN restarts at slot 0 with a full blank.
- rst_n has priority over EN. A mid-slot reset yields reset values on the following cycle with no partial-slot residue.
- AN never has more than one bit low, and never has a bit low during BLANK or IDLE.

## Timing
- Every slot is exactly PRESCALE cycles: BLANK_CYCLES blank plus PRESCALE−BLANK_CYCLES on. One frame is 4·PRESCALE cycles; the FRAME period is 4·PRESCALE.
- EN rising at edge E0 gives:
  - Cycles E0 .. E0+BLANK_CYCLES: BLANK for slot 0.
  - Edge E0+BLANK_CYCLES: AN goes low for digit 0.
  - Edge E0+PRESCALE: S becomes 1 and AN returns to 4'hF.
- S changes only on slot boundaries, at the first blank edge. The mux output therefore settles during the blank interval.
- SEG_OUT lags SEG_IN by one cycle during ON.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle, PRESCALE=8, BLANK_CYCLES=2: assert rst_n=0 for 3 cycles with EN=1, then keep EN=0 → S=0, AN=4'hF, SEG_OUT=7'h7F, FRAME=0 throughout.
- Full sweep, MASK=4'hF, SEG_IN driven as a function of S (0x40, 0x79, 0x24, 0x30) → per 8-cycle slot: 2 cycles AN=F/SEG=7F, then 6 cycles with AN = E, D, B, 7 in turn and SEG_OUT equal to the matching pattern. FRAME is a single pulse 32 cycles apart, with the first pulse 32 cycles after EN rises.
- Masking: MASK=4'b1010 → slots 0 and 2 keep AN=F and SEG_OUT=7F; slots 1 and 3 show AN=D and AN=7. Slot timing is unchanged.
- Mid-slot MASK change: clear MASK[1] at cycle 4 of slot 1 → digit 1 stays lit for the rest of slot 1 and is dark in the next frame.
- EN drop mid-ON in slot 2, re-assert 5 cycles later → outputs go to reset values on the next edge. The restart begins at S=0 with 2 blank cycles. No FRAME pulse for the aborted frame.
- Synchronous reset at cnt=5 of slot 3 (edge where the wrap would be near) → reset values on the next cycle, no FRAME pulse. With EN still high, restart at S=0.
